// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 move datapath.
package game2048_pkg;

  localparam int TILE_W  = 12;
  localparam int SCORE_W = 16;

  typedef logic [TILE_W-1:0] tile_t;
  typedef tile_t [3:0]       line_t;
  typedef tile_t [3:0][3:0]  board_t;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam tile_t TILE_MAX = tile_t'(2048);

endpackage

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one 4-cell line toward index 0.
// Max-tile detection is built only with BOARD_SLIDE_MERGE_WIN_EN.
module line_merge
  import game2048_pkg::*;
(
  input  line_t              i_line,
  output line_t              o_line,
  output logic [SCORE_W-1:0] o_sum,
  output logic               o_made_max
);

  // Compressed line with a zero sentinel in slot 4 so the pair compare never runs off the end.
  tile_t      w_c [5];
  logic [2:0] w_n;

  always_comb begin
    for (int j = 0; j < 5; j++) w_c[j] = '0;
    w_n = '0;
    for (int j = 0; j < 4; j++) begin
      if (i_line[j] != '0) begin
        w_c[w_n] = i_line[j];
        w_n      = w_n + 3'd1;
      end
    end
  end

  logic       w_skip;
  logic [2:0] w_k;
  tile_t      w_pair;

  always_comb begin
    o_line     = '0;
    o_sum      = '0;
    o_made_max = 1'b0;
    w_skip     = 1'b0;
    w_k        = '0;
    w_pair     = '0;
    for (int j = 0; j < 4; j++) begin
      w_pair = w_c[j] + w_c[j+1];
      if (w_skip) begin
        w_skip = 1'b0;
      end else if (w_c[j] != '0 && w_c[j] == w_c[j+1] && w_c[j] != TILE_MAX) begin
        o_line[w_k[1:0]] = w_pair;
        o_sum            = o_sum + SCORE_W'(w_pair);
`ifdef BOARD_SLIDE_MERGE_WIN_EN
        o_made_max       = o_made_max | (w_pair == TILE_MAX);
`endif
        w_skip           = 1'b1;
        w_k              = w_k + 3'd1;
      end else if (w_c[j] != '0) begin
        o_line[w_k[1:0]] = w_c[j];
        w_k              = w_k + 3'd1;
      end
    end
  end

endmodule

// File: rtl/board_slide_merge.sv
// 2048 move engine: captures a board and direction, merges one line per clock.
// Optional win flag built with BOARD_SLIDE_MERGE_WIN_EN; otherwise win is tied 0.
//
// state     | meaning
// ST_IDLE   | result held, waiting for start
// ST_SHIFT  | merging line r_idx (0..3)
// ST_FINISH | compare against original, raise done
module board_slide_merge
  import game2048_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    dir,
  input  logic [3:0][3:0][TILE_W-1:0]   board_in,
  output logic [3:0][3:0][TILE_W-1:0]   board_out,
  output logic                          moved,
  output logic [SCORE_W-1:0]            score_delta,
  output logic                          win,
  output logic                          done
);

  state_t             r_state;
  board_t             r_work;
  board_t             r_orig;
  dir_t               r_dir;
  logic [1:0]         r_idx;
  logic [SCORE_W-1:0] r_score;
  logic               r_moved;
  logic               r_done;

  line_t              w_line;
  line_t              w_merged;
  logic [SCORE_W-1:0] w_sum;
  board_t             w_next;

  // Lines are presented leading-edge first so one merge unit serves every direction.
  always_comb begin
    w_line = '0;
    for (int k = 0; k < 4; k++) begin
      case (r_dir)
        DIR_LEFT:  w_line[k] = r_work[r_idx][k];
        DIR_RIGHT: w_line[k] = r_work[r_idx][3-k];
        DIR_UP:    w_line[k] = r_work[k][r_idx];
        default:   w_line[k] = r_work[3-k][r_idx];
      endcase
    end
  end

  always_comb begin
    w_next = r_work;
    for (int k = 0; k < 4; k++) begin
      case (r_dir)
        DIR_LEFT:  w_next[r_idx][k]   = w_merged[k];
        DIR_RIGHT: w_next[r_idx][3-k] = w_merged[k];
        DIR_UP:    w_next[k][r_idx]   = w_merged[k];
        default:   w_next[3-k][r_idx] = w_merged[k];
      endcase
    end
  end

`ifdef BOARD_SLIDE_MERGE_WIN_EN
  logic w_made_max;
`else
  logic w_unused_made_max;
`endif

  line_merge u_line_merge (
    .i_line     (w_line),
    .o_line     (w_merged),
    .o_sum      (w_sum),
`ifdef BOARD_SLIDE_MERGE_WIN_EN
    .o_made_max (w_made_max)
`else
    .o_made_max (w_unused_made_max)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_orig  <= '0;
      r_dir   <= DIR_LEFT;
      r_idx   <= '0;
      r_score <= '0;
      r_moved <= 1'b0;
      r_done  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_work  <= board_in;
            r_orig  <= board_in;
            r_dir   <= dir_t'(dir);
            r_score <= '0;
            r_moved <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_work  <= w_next;
          r_score <= r_score + w_sum;
          r_idx   <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          r_moved <= (r_work != r_orig);
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef BOARD_SLIDE_MERGE_WIN_EN
  logic r_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_win <= 1'b0;
    end else if (r_state == ST_SHIFT && w_made_max) begin
      r_win <= 1'b1;
    end
  end

  assign win = r_win;
`else
  assign win = 1'b0;
`endif

  assign board_out   = r_work;
  assign moved       = r_moved;
  assign score_delta = r_score;
  assign done        = r_done;

endmodule

// File: tb/tb_board_slide_merge.sv
// Scoreboard bench for board_slide_merge: directed moves with hand-computed results.
module tb_board_slide_merge;
  import game2048_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [1:0]          dir;
  board_t              board_in;
  board_t              board_out;
  logic                moved;
  logic [SCORE_W-1:0]  score_delta;
  logic                win;
  logic                done;

  board_slide_merge dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dir         (dir),
    .board_in    (board_in),
    .board_out   (board_out),
    .moved       (moved),
    .score_delta (score_delta),
    .win         (win),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    board_t             b;
    logic               m;
    logic [SCORE_W-1:0] s;
    logic               w;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

`ifdef BOARD_SLIDE_MERGE_WIN_EN
  localparam logic WIN_EXP = 1'b1;
`else
  localparam logic WIN_EXP = 1'b0;
`endif

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic board_t set_row(board_t b, int r, int c0, int c1, int c2, int c3);
    board_t t = b;
    t[r][0] = tile_t'(c0); t[r][1] = tile_t'(c1);
    t[r][2] = tile_t'(c2); t[r][3] = tile_t'(c3);
    return t;
  endfunction

  function automatic board_t set_col(board_t b, int c, int r0, int r1, int r2, int r3);
    board_t t = b;
    t[0][c] = tile_t'(r0); t[1][c] = tile_t'(r1);
    t[2][c] = tile_t'(r2); t[3][c] = tile_t'(r3);
    return t;
  endfunction

  // Monitor: every done rise not caused by reset is a completed move.
  logic rst_at_edge = 1'b1;
  logic prev_done   = 1'b1;
  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (done === 1'b1 && prev_done === 1'b0 && rst_at_edge === 1'b0) begin
      if (q.size() == 0) begin
        check("unexpected_done", 192'd1, 192'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("board_out",   board_out,   e.b);
        check("moved",       moved,       e.m);
        check("score_delta", score_delta, e.s);
        check("win",         win,         e.w);
      end
    end
    prev_done = done;
  end

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("done_timeout", 192'd0, 192'd1);
      q.delete();
    end
  endtask

  // Drives one move; also scrambles board_in and pulses start mid-move, both of which must be ignored.
  task automatic do_move(input board_t b, input logic [1:0] d, input board_t eb,
                         input logic em, input int es, input logic ew);
    exp_t e;
    e.b = eb; e.m = em; e.s = SCORE_W'(es); e.w = ew;
    q.push_back(e);
    @(posedge clk); #2;
    board_in = b; dir = d; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; board_in = ~b; dir = ~d;
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_drain();
  endtask

  board_t b, e;

  initial begin
    rst = 1'b1; start = 1'b0; dir = 2'd0; board_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_board", board_out, 192'd0);
    check("rst_done",  done, 192'd1);
    check("rst_moved", moved, 192'd0);
    check("rst_score", score_delta, 192'd0);
    check("rst_win",   win, 192'd0);
    @(posedge clk); #2; rst = 1'b0;

    b = set_row('0, 0, 2, 2, 2, 2);   e = set_row('0, 0, 4, 4, 0, 0);
    do_move(b, 2'd0, e, 1'b1, 8, 1'b0);

    b = set_row('0, 0, 2, 2, 4, 0);   e = set_row('0, 0, 4, 4, 0, 0);
    do_move(b, 2'd0, e, 1'b1, 4, 1'b0);

    b = set_col('0, 1, 4, 0, 4, 8);   e = set_col('0, 1, 0, 0, 8, 8);
    do_move(b, 2'd3, e, 1'b1, 8, 1'b0);

    b = set_row('0, 0, 2, 4, 8, 16);
    do_move(b, 2'd0, b, 1'b0, 0, 1'b0);

    b = set_row('0, 3, 1024, 1024, 2048, 2048);
    e = set_row('0, 3, 0, 2048, 2048, 2048);
    do_move(b, 2'd1, e, 1'b1, 2048, WIN_EXP);

    do_move('0, 2'd3, '0, 1'b0, 0, 1'b0);

    b = set_col('0, 0, 2, 2, 0, 4);   b = set_col(b, 3, 0, 0, 0, 2);
    e = set_col('0, 0, 4, 4, 0, 0);   e = set_col(e, 3, 2, 0, 0, 0);
    do_move(b, 2'd2, e, 1'b1, 4, 1'b0);

    // Reset mid-move, then restart on the edge right after the reset.
    @(posedge clk); #2;
    board_in = set_row('0, 1, 8, 8, 0, 0); dir = 2'd0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    b = set_row('0, 2, 0, 16, 0, 16);  e = set_row('0, 2, 32, 0, 0, 0);
    begin
      exp_t x;
      x.b = e; x.m = 1'b1; x.s = SCORE_W'(32); x.w = 1'b0;
      q.push_back(x);
    end
    board_in = b; dir = 2'd0; start = 1'b1;
    #3;
    check("midrst_board", board_out, 192'd0);
    check("midrst_done",  done, 192'd1);
    check("midrst_score", score_delta, 192'd0);
    @(posedge clk); #2;
    start = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
